// File: rtl/dct32_synth_window.sv
// dct32_synth_window: polyphase synthesis window at the consumer end of the
// dct32 subband interface. It accepts a 32-word frame, stores it in a
// 16-phase history ring, runs a serial MAC against an external window ROM,
// and streams 32 PCM samples per frame.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   lo, hi               dct32 result halves (words 0..15 and 16..31), signed
//   in_valid / in_ready  frame handshake; in_ready is high only in IDLE
//   coef_addr            window ROM address, {tap k, sample j}
//   coef_data            ROM data, one cycle after coef_addr
//   pcm / pcm_valid      PCM sample stream with pcm_ready backpressure
//   pcm_last             marks sample 31 of a frame
//   busy                 high whenever the block is not idle
//
// Build option: define SYNTH_PCM_SAT_EN to clamp PCM to the signed OUTW
// range; otherwise the rounded sample wraps to its low OUTW bits.
module dct32_synth_window #(
  parameter int unsigned DW     = 32,
  parameter int unsigned ACCW   = 64,
  parameter int unsigned NPHASE = 16,
  parameter int unsigned OUTW   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0][DW-1:0]   lo,
  input  logic [15:0][DW-1:0]   hi,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [8:0]            coef_addr,
  input  logic [DW-1:0]         coef_data,
  output logic [OUTW-1:0]       pcm,
  output logic                  pcm_valid,
  input  logic                  pcm_ready,
  output logic                  pcm_last,
  output logic                  busy
);

  localparam int unsigned NWORD = 32;
  localparam int unsigned WW    = 5;
  localparam int unsigned PW    = $clog2(NPHASE);
  localparam int unsigned AW    = 9;
  localparam int unsigned PRODW = 2 * DW;
  localparam int unsigned FRAC  = 28;
  localparam int unsigned RSH   = 13;

  localparam logic [WW-1:0] LAST_WORD = 5'd31;
  localparam logic [WW-1:0] LAST_ADDR = 5'd15;
  localparam logic [WW-1:0] LAST_TAP  = 5'd16;
  localparam logic [WW-1:0] CONV_CYC  = 5'd17;

  localparam logic signed [ACCW-1:0] ROUND = ACCW'(1) << (RSH - 1);
`ifdef SYNTH_PCM_SAT_EN
  localparam logic signed [ACCW-1:0] PCM_MAX = ACCW'((2 ** (OUTW - 1)) - 1);
  localparam logic signed [ACCW-1:0] PCM_MIN = ~PCM_MAX;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_OUT} state_t;

  state_t                    state;
  logic [PW-1:0]             wp;
  logic [NPHASE-1:0]         valid_mask;
  logic [NWORD-1:0][DW-1:0]  frame_q;
  logic [WW-1:0]             lcnt;
  logic [WW-1:0]             cyc;
  logic [WW-1:0]             j;
  logic signed [ACCW-1:0]    acc;

  // History ring: slot-major, word-minor; intentionally not reset
  logic [DW-1:0]             hist [NPHASE*NWORD];

  logic [PW-1:0]             tap;
  logic [PW-1:0]             rd_slot;
  logic [WW-1:0]             rd_word;
  logic signed [PRODW-1:0]   prod;
  logic signed [ACCW-1:0]    acc_rnd;
  logic [OUTW-1:0]           pcm_n;
`ifdef SYNTH_PCM_SAT_EN
  logic signed [ACCW-1:0]    r;
`endif

  assign in_ready = (state == S_IDLE);

  // One captured word per LOAD cycle into the newest slot
  always_ff @(posedge clk) begin
    if (state == S_LOAD) hist[{wp, lcnt}] <= frame_q[lcnt];
  end

  // Tap read aligned with coef_data: MAC cycle c consumes tap c-1.
  // Odd taps read the mirrored word 31-j (~j on 5 bits).
  always_comb begin
    tap     = PW'(cyc - 5'd1);
    rd_slot = wp - tap;
    rd_word = tap[0] ? ~j : j;
    prod    = '0;
    if (valid_mask[rd_slot]) begin
      prod = $signed(hist[{rd_slot, rd_word}]) * $signed(coef_data);
    end
  end

  // Fixed-point to PCM: drop 28 fractional bits, round-half-up by 13 bits
  always_comb begin
    acc_rnd = (acc >>> FRAC) + ROUND;
`ifdef SYNTH_PCM_SAT_EN
    r = acc_rnd >>> RSH;
    if (r > PCM_MAX)      pcm_n = OUTW'(PCM_MAX);
    else if (r < PCM_MIN) pcm_n = OUTW'(PCM_MIN);
    else                  pcm_n = OUTW'(r);
`else
    pcm_n = OUTW'(acc_rnd >>> RSH);
`endif
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wp         <= '0;
      valid_mask <= '0;
      frame_q    <= '0;
      lcnt       <= '0;
      cyc        <= '0;
      j          <= '0;
      acc        <= '0;
      coef_addr  <= '0;
      pcm        <= '0;
      pcm_valid  <= 1'b0;
      pcm_last   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            frame_q <= {hi, lo};
            wp      <= wp + PW'(1);
            lcnt    <= '0;
            busy    <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          lcnt <= lcnt + 5'd1;
          if (lcnt == LAST_WORD) begin
            valid_mask[wp] <= 1'b1;
            j         <= '0;
            cyc       <= '0;
            acc       <= '0;
            coef_addr <= '0;
            state     <= S_MAC;
          end
        end
        S_MAC: begin
          cyc <= cyc + 5'd1;
          // Address for tap k is presented during MAC cycle k
          if (cyc < LAST_ADDR) coef_addr <= AW'({PW'(cyc + 5'd1), j});
          if (cyc != 5'd0 && cyc <= LAST_TAP) acc <= acc + ACCW'(prod);
          if (cyc == CONV_CYC) begin
            pcm       <= pcm_n;
            pcm_valid <= 1'b1;
            pcm_last  <= (j == LAST_WORD);
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (pcm_ready) begin
            pcm_valid <= 1'b0;
            pcm_last  <= 1'b0;
            if (j == LAST_WORD) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              j         <= j + 5'd1;
              cyc       <= '0;
              acc       <= '0;
              coef_addr <= AW'({PW'(0), j + 5'd1});
              state     <= S_MAC;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
